// File: rtl/framebuffer_pkg.sv
// Shared framebuffer types: pending-write entry layout and requester indices.
package framebuffer_pkg;

    localparam int FB_ADDR_WIDTH = 17;
    localparam int FB_DATA_WIDTH = 8;

    // Packed so the entry is bit-identical to pendingWriteQueueReadBus.
    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0] address;
        logic [FB_DATA_WIDTH-1:0] data;
    } pending_write_t;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_BLIT = 1'b1;

endpackage

// File: rtl/sync_showahead_fifo.sv
// Synchronous show-ahead FIFO: head entry is presented combinationally, zero when empty.
module sync_showahead_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 25,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap by natural overflow, which relies on DEPTH being a power of two.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        head_data = empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q <= DEPTH_C);
        end
    end

endmodule

// File: rtl/write_queue_arbiter.sv
// Round-robin arbiter sharing the pending-write queue between host and blitter.
module write_queue_arbiter
    import framebuffer_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter  int DATA_WIDTH = FB_DATA_WIDTH,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             hostWriteValid,
    input  logic [ADDR_WIDTH-1:0]            hostWriteAddress,
    input  logic [DATA_WIDTH-1:0]            hostWriteData,
    output logic                             hostWriteReady,
    input  logic                             blitWriteValid,
    input  logic [ADDR_WIDTH-1:0]            blitWriteAddress,
    input  logic [DATA_WIDTH-1:0]            blitWriteData,
    output logic                             blitWriteReady,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] pendingWriteQueueReadBus,
    output logic                             pendingWriteQueueReadEmpty,
    input  logic                             pendingWriteQueueReadRequest,
    output logic [CNT_W-1:0]                 queueCount,
    output logic                             lastGrantBlit
);

    logic           last_grant_q, last_grant_d;
    logic           grant_valid;
    logic           grant_req;
    logic           push;
    logic           fifo_full;
    pending_write_t push_entry;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant_valid = hostWriteValid || blitWriteValid;
        if (hostWriteValid && blitWriteValid) begin
            grant_req = (last_grant_q == REQ_BLIT) ? REQ_HOST : REQ_BLIT;
        end else if (blitWriteValid) begin
            grant_req = REQ_BLIT;
        end else begin
            grant_req = REQ_HOST;
        end
        hostWriteReady     = grant_valid && (grant_req == REQ_HOST) && !fifo_full;
        blitWriteReady     = grant_valid && (grant_req == REQ_BLIT) && !fifo_full;
        push               = (hostWriteValid && hostWriteReady) || (blitWriteValid && blitWriteReady);
        push_entry.address = (grant_req == REQ_BLIT) ? blitWriteAddress : hostWriteAddress;
        push_entry.data    = (grant_req == REQ_BLIT) ? blitWriteData    : hostWriteData;
        last_grant_d       = push ? grant_req : last_grant_q;
        lastGrantBlit      = (last_grant_q == REQ_BLIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= REQ_HOST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    sync_showahead_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pending_write_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pendingWriteQueueReadRequest),
        .head_data (pendingWriteQueueReadBus),
        .empty     (pendingWriteQueueReadEmpty),
        .full      (fifo_full),
        .count     (queueCount)
    );

endmodule

// File: tb/tb_write_queue_arbiter.sv
// Scoreboard bench for write_queue_arbiter: directed scenarios followed by randomized traffic.
module tb_write_queue_arbiter;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        host_valid = 1'b0;
    logic [16:0] host_address = '0;
    logic [7:0]  host_data = '0;
    logic        host_ready;
    logic        blit_valid = 1'b0;
    logic [16:0] blit_address = '0;
    logic [7:0]  blit_data = '0;
    logic        blit_ready;
    logic [24:0] read_bus;
    logic        read_empty;
    logic        read_request = 1'b0;
    logic [3:0]  queue_count;
    logic        last_grant_blit;

    int          n_checks = 0;
    int          n_passed = 0;
    int          model_count = 0;
    bit          model_last_blit = 1'b0;
    logic [24:0] sb_q[$];
    bit          grant_log[$];
    bit          host_acc = 1'b0;
    bit          blit_acc = 1'b0;
    int          push_total = 0;

    always #5 clock = ~clock;

    write_queue_arbiter #(.DEPTH(DEPTH)) dut (
        .clock                        (clock),
        .reset                        (reset),
        .hostWriteValid               (host_valid),
        .hostWriteAddress             (host_address),
        .hostWriteData                (host_data),
        .hostWriteReady               (host_ready),
        .blitWriteValid               (blit_valid),
        .blitWriteAddress             (blit_address),
        .blitWriteData                (blit_data),
        .blitWriteReady               (blit_ready),
        .pendingWriteQueueReadBus     (read_bus),
        .pendingWriteQueueReadEmpty   (read_empty),
        .pendingWriteQueueReadRequest (read_request),
        .queueCount                   (queue_count),
        .lastGrantBlit                (last_grant_blit)
    );

    // 0 = nobody, 1 = host, 2 = blitter
    function automatic int exp_grant(bit hv, bit bv, bit last_blit);
        if (hv && bv) return last_blit ? 1 : 2;
        if (hv) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Requesters hold valid/address/data until accepted, then optionally issue a fresh write.
    task automatic applyStimulus(input bit want_host, input bit want_blit, input bit rd, input bit rst);
        @(negedge clock);
        if (!host_valid || host_acc) begin
            host_valid   = want_host;
            host_address = 17'($urandom_range(0, 131071));
            host_data    = 8'($urandom_range(0, 255));
        end
        if (!blit_valid || blit_acc) begin
            blit_valid   = want_blit;
            blit_address = 17'($urandom_range(0, 131071));
            blit_data    = 8'($urandom_range(0, 255));
        end
        read_request = rd;
        reset        = rst;
    endtask

    // Reference model: queue of accepted writes plus round-robin memory, advanced on each edge.
    always @(posedge clock) begin : model_blk
        int g;
        bit pushed;
        bit popped;
        g        = exp_grant(host_valid, blit_valid, model_last_blit);
        host_acc = 1'b0;
        blit_acc = 1'b0;
        if (reset) begin
            model_count     = 0;
            model_last_blit = 1'b0;
            sb_q.delete();
        end else begin
            pushed = (g != 0) && (model_count < DEPTH);
            popped = read_request && (model_count > 0);
            if (pushed) begin
                if (g == 1) begin
                    sb_q.push_back({host_address, host_data});
                    host_acc        = 1'b1;
                    model_last_blit = 1'b0;
                end else begin
                    sb_q.push_back({blit_address, blit_data});
                    blit_acc        = 1'b1;
                    model_last_blit = 1'b1;
                end
                grant_log.push_back(g == 2);
                push_total++;
            end
            model_count = model_count + int'(pushed) - int'(popped);
        end
    end

    // Monitor: compares every cycle's outputs and pops the scoreboard when a read is taken.
    always @(negedge clock) begin : monitor_blk
        int          g;
        bit          full;
        logic [24:0] exp_bus;
        #2;
        g    = exp_grant(host_valid, blit_valid, model_last_blit);
        full = (model_count == DEPTH);
        checkOutput("host_ready", 32'(host_ready), 32'(g == 1 && !full));
        checkOutput("blit_ready", 32'(blit_ready), 32'(g == 2 && !full));
        checkOutput("empty", 32'(read_empty), 32'(model_count == 0));
        checkOutput("count", 32'(queue_count), 32'(model_count));
        checkOutput("last_grant_blit", 32'(last_grant_blit), 32'(model_last_blit));
        if (model_count == 0) begin
            checkOutput("idle_bus", 32'(read_bus), 32'h0);
        end else if (read_request) begin
            exp_bus = sb_q.pop_front();
            checkOutput("pop_data", 32'(read_bus), 32'(exp_bus));
        end else begin
            exp_bus = sb_q[0];
            checkOutput("head_data", 32'(read_bus), 32'(exp_bus));
        end
    end

    initial begin
        int start;
        int blits;

        repeat (2) applyStimulus(0, 0, 0, 1);
        #3;
        checkOutput("reset_empty", 32'(read_empty), 32'h1);
        checkOutput("reset_count", 32'(queue_count), 32'h0);
        checkOutput("reset_bus", 32'(read_bus), 32'h0);

        // First host write with a known entry
        @(negedge clock);
        reset        = 1'b0;
        host_valid   = 1'b1;
        host_address = 17'h00010;
        host_data    = 8'hAA;
        #3;
        checkOutput("first_host_ready", 32'(host_ready), 32'h1);
        applyStimulus(0, 0, 0, 0);
        #3;
        checkOutput("first_empty", 32'(read_empty), 32'h0);
        checkOutput("first_bus", 32'(read_bus), 32'h00010AA);
        checkOutput("first_count", 32'(queue_count), 32'h1);

        // Continuous contention from reset: grants must alternate starting with the blitter
        applyStimulus(0, 0, 0, 1);
        grant_log.delete();
        start = push_total;
        for (int i = 0; i < 200 && (push_total - start) < 16; i++) begin
            applyStimulus(1, 1, 1, 0);
        end
        checkOutput("rr_push_total", 32'(push_total - start >= 16), 32'h1);
        if (grant_log.size() >= 16) begin
            checkOutput("rr_grant0", 32'(grant_log[0]), 32'h1);
            checkOutput("rr_grant1", 32'(grant_log[1]), 32'h0);
            checkOutput("rr_grant2", 32'(grant_log[2]), 32'h1);
            checkOutput("rr_grant3", 32'(grant_log[3]), 32'h0);
            blits = 0;
            for (int i = 0; i < 16; i++) blits += int'(grant_log[i]);
            checkOutput("rr_blit_share", 32'(blits), 32'd8);
        end
        repeat (12) applyStimulus(0, 0, 1, 0);

        // Fill to DEPTH, then free one slot
        applyStimulus(0, 0, 0, 1);
        repeat (10) applyStimulus(1, 0, 0, 0);
        #3;
        checkOutput("full_count", 32'(queue_count), 32'd8);
        checkOutput("full_host_ready", 32'(host_ready), 32'h0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        #3;
        checkOutput("after_pop_ready", 32'(host_ready), 32'h1);
        applyStimulus(0, 0, 0, 0);
        #3;
        checkOutput("ninth_accepted_count", 32'(queue_count), 32'd8);

        // Read request outlasting the queue contents
        applyStimulus(0, 0, 0, 1);
        repeat (2) applyStimulus(1, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        #3;
        checkOutput("overread_count", 32'(queue_count), 32'h0);
        checkOutput("overread_empty", 32'(read_empty), 32'h1);
        checkOutput("overread_bus", 32'(read_bus), 32'h0);

        // Simultaneous push and pop at count 4, then mixed traffic across pointer wrap
        applyStimulus(0, 0, 0, 1);
        repeat (4) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        #3;
        checkOutput("push_pop_count", 32'(queue_count), 32'd4);
        repeat (20) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        repeat (12) applyStimulus(0, 0, 1, 0);

        // Reset with entries queued while push and pop are both active
        applyStimulus(0, 0, 0, 1);
        repeat (5) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        #3;
        checkOutput("midreset_count", 32'(queue_count), 32'h0);
        checkOutput("midreset_empty", 32'(read_empty), 32'h1);
        checkOutput("midreset_last", 32'(last_grant_blit), 32'h0);
        checkOutput("midreset_bus", 32'(read_bus), 32'h0);

        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));
        end
        repeat (20) applyStimulus(0, 0, 1, 0);
        #3;
        checkOutput("final_count", 32'(queue_count), 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/write_queue_arbiter.md
Name: write_queue_arbiter

Overview:
- Shares the framebuffer's pending-write queue between two write requesters: host bus interface and blitter.
- Round-robin arbitration; accepted writes are buffered in a show-ahead FIFO.
- The read side drives the memory manager's pendingWriteQueueRead* interface directly.
- Sits between the host/blitter and the memory manager; replaces the vendor FIFO on that path.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ADDR_WIDTH, 17, framebuffer address bits ({y[7:0], x[8:0]}).
- DATA_WIDTH, 8, pixel bits.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- hostWriteValid  input  1  host has a write pending.
- hostWriteAddress  input  17  host write address.
- hostWriteData  input  8  host pixel.
- hostWriteReady  output  1  host write accepted this cycle when high with valid.
- blitWriteValid  input  1  blitter has a write pending.
- blitWriteAddress  input  17  blitter write address.
- blitWriteData  input  8  blitter pixel.
- blitWriteReady  output  1  blitter write accepted this cycle when high with valid.
- pendingWriteQueueReadBus  output  25  head entry {address[24:8], data[7:0]}.
- pendingWriteQueueReadEmpty  output  1  FIFO empty.
- pendingWriteQueueReadRequest  input  1  pop request from the memory manager.
- queueCount  output  4  occupancy, 0..DEPTH (width $clog2(DEPTH)+1).
- lastGrantBlit  output  1  1 if the most recent accepted push came from the blitter.

Behaviour:
- Reset (synchronous, active-high): count=0, read/write pointers=0, lastGrantBlit=0.
  - Outputs after reset: empty=1, both ready=0 unless a valid is present, readBus=0.
  - Reset mid-operation discards all queued entries. Any push or pop in the reset cycle is ignored.
- Grant is combinational from the valids:
  - Only one valid: that requester is granted.
  - Both valid: the requester not named by lastGrantBlit is granted (lastGrantBlit=0 → blit, 1 → host).
  - Neither valid: no grant.
- Ready:
  - xReady = granted(x) && (count < DEPTH).
  - The non-granted requester's ready is 0.
  - Ready never depends on that requester's own ready (no loops).
- Push happens when ready && valid. Entry {address, data} is written at wrPtr; wrPtr advances, wrapping modulo DEPTH. lastGrantBlit updates on the same edge.
- Requester rule: valid, address and data are held stable until ready. The bench checks this; the block does not.
- Read side (show-ahead):
  - readBus = mem[rdPtr] combinationally whenever !empty; 0 when empty.
  - Empty = (count == 0).
- Pop happens on an edge where readRequest && !empty; rdPtr advances, wrapping.
  - The consumer latches readBus on that same edge.
  - readRequest while empty is ignored: no pointer or count change.
- readRequest may stay high for consecutive cycles; each cycle with !empty pops one entry.
- Simultaneous push and pop:
  - count unchanged.
  - When count == DEPTH, push is blocked because ready=0; the pop proceeds.
  - When count == 0, the pushed entry is not visible on readBus until the next cycle (no bypass). The pop is ignored.
- Count arithmetic: count + push − pop, no saturation needed. Overflow and underflow are impossible by construction; an assertion checks 0 ≤ count ≤ DEPTH.
- Latency: push at edge N makes the entry visible on readBus and clears empty after edge N (queue previously empty).
- Ordering: strict FIFO across both requesters, in grant order.

Decomposition:
- Package framebuffer_pkg:
  - FB_ADDR_WIDTH=17, FB_DATA_WIDTH=8.
  - typedef struct packed {logic [16:0] address; logic [7:0] data;} pending_write_t (25 bits, packed to match readBus).
  - Requester index constants REQ_HOST=0, REQ_BLIT=1.
- Sub-module sync_showahead_fifo, parameterised on DEPTH and width. It holds storage, pointers and count.
- The arbiter top holds grant logic, lastGrantBlit and the ready gating.

Test Plan:
- Reset, then host pushes addr 0x00010, data 0xAA → hostWriteReady=1 on that cycle. Next cycle: empty=0, readBus=0x001_0AA (addr in [24:8]), queueCount=1.
- Host and blit both valid continuously, from reset → grants alternate blit, host, blit, host. Pop order matches, with no starvation over 16 pushes.
- Fill with 8 host writes, no pops → queueCount=8, hostWriteReady=0 while valid held. One pop → ready=1 the following cycle and the 9th write is accepted.
- readRequest high for 3 cycles with 2 entries queued → 2 pops; third cycle ignored, count stays 0, empty=1, readBus=0.
- Count=4, simultaneous blit push and pop → count stays 4. Popped entry is the old head and the new entry lands at the tail. Pointers wrap correctly after 20 mixed operations; scoreboard matches.
- Assert reset with 5 entries queued while a push and pop are active → next cycle count=0, empty=1, lastGrantBlit=0, and no entry from the reset cycle survives.
